// File: rtl/fpnew_ordered_dispatch.sv
// Dispatches tagged operations to a set of operation-group units and retires
// their results in program order through a small {group, tag} order FIFO.
module fpnew_ordered_dispatch #(
   parameter int NumGroups = 5,
   parameter int Width     = 64,
   parameter int Depth     = 8,
   parameter int TagWidth  = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [$clog2(NumGroups)-1:0]  in_group_i,
   input  logic [TagWidth-1:0]           in_tag_i,
   output logic [NumGroups-1:0]          grp_in_valid_o,
   input  logic [NumGroups-1:0]          grp_in_ready_i,
   input  logic [NumGroups-1:0]          grp_out_valid_i,
   output logic [NumGroups-1:0]          grp_out_ready_o,
   input  logic [NumGroups*Width-1:0]    grp_result_i,
   input  logic [NumGroups*5-1:0]        grp_status_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [Width-1:0]              result_o,
   output logic [4:0]                    status_o,
   output logic [TagWidth-1:0]           tag_o,
   input  logic                          flush_i,
   output logic                          busy_o,
   output logic [$clog2(Depth+1)-1:0]    outstanding_o,
   output logic                          err_o
);

   localparam int GrpW = $clog2(NumGroups);
   localparam int PtrW = $clog2(Depth);
   localparam int CntW = $clog2(Depth + 1);
   localparam logic [CntW-1:0] CntFull    = CntW'(Depth);
   localparam logic [GrpW:0]   NumGroupsW = (GrpW + 1)'(NumGroups);

   logic [GrpW-1:0]     grp_mem_q [Depth];
   logic [TagWidth-1:0] tag_mem_q [Depth];

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            err_q, err_d;

   logic                 legal;
   logic                 full;
   logic                 not_empty;
   logic                 admit;
   logic                 push;
   logic                 pop;
   logic [GrpW-1:0]      head_grp;
   logic [NumGroups-1:0] in_sel;
   logic [NumGroups-1:0] head_sel;
   logic [Width-1:0]     head_result;
   logic [4:0]           head_status;

   // Extra MSB keeps the compare exact when NumGroups is a power of two.
   assign legal     = ({1'b0, in_group_i} < NumGroupsW);
   assign full      = (count_q == CntFull);
   assign not_empty = (count_q != '0);
   assign head_grp  = grp_mem_q[rd_ptr_q];

   for (genvar gi = 0; gi < NumGroups; gi++) begin : g_sel
      assign in_sel[gi]   = (in_group_i == GrpW'(gi));
      assign head_sel[gi] = (head_grp == GrpW'(gi));
   end

   // A full FIFO blocks dispatch regardless of a same-cycle retire.
   assign admit          = in_valid_i & legal & ~full & ~flush_i;
   assign grp_in_valid_o = admit ? in_sel : '0;
   assign push           = admit & |(in_sel & grp_in_ready_i);
   assign in_ready_o     = push;

   assign out_valid_o     = not_empty & |(head_sel & grp_out_valid_i) & ~flush_i;
   assign grp_out_ready_o = flush_i ? '1 : ((out_ready_i & not_empty) ? head_sel : '0);
   assign pop             = out_valid_o & out_ready_i;

   always_comb begin
      head_result = '0;
      head_status = '0;
      for (int g = 0; g < NumGroups; g++) begin
         if (head_sel[g]) begin
            head_result = grp_result_i[g*Width +: Width];
            head_status = grp_status_i[g*5 +: 5];
         end
      end
   end

   assign result_o      = not_empty ? head_result : '0;
   assign status_o      = not_empty ? head_status : '0;
   assign tag_o         = not_empty ? tag_mem_q[rd_ptr_q] : '0;
   assign busy_o        = not_empty;
   assign outstanding_o = count_q;
   assign err_o         = err_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q | (in_valid_i & ~legal);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   // Entries need no reset: the count masks every stale slot.
   always_ff @(posedge clk_i) begin
      if (push) begin
         grp_mem_q[wr_ptr_q] <= in_group_i;
         tag_mem_q[wr_ptr_q] <= in_tag_i;
      end
   end

endmodule

// File: doc/fpnew_ordered_dispatch.md
FPNEW_ORDERED_DISPATCH -- requirements
Module: fpnew_ordered_dispatch

Interface
REQ-001 SHALL have parameter NumGroups, default 5: number of operation-group channels (2..16).
REQ-002 SHALL have parameter Width, default 64: result width in bits.
REQ-003 SHALL have parameter Depth, default 8: max in-flight operations (power of two, 2..64).
REQ-004 SHALL have parameter TagWidth, default 8: width of the tag carried per operation.
REQ-005 SHALL use one clock; reset is synchronous and active-high: clk_i input 1 rising-edge clock; rst_i input 1 sync active-high reset.
REQ-006 SHALL have in_valid_i input 1: dispatch request.
REQ-007 SHALL have in_ready_o output 1: dispatch accepted.
REQ-008 SHALL have in_group_i input $clog2(NumGroups): target group.
REQ-009 SHALL have in_tag_i input TagWidth: operation tag.
REQ-010 SHALL have grp_in_valid_o output NumGroups: per-group dispatch valid.
REQ-011 SHALL have grp_in_ready_i input NumGroups: per-group dispatch ready.
REQ-012 SHALL have grp_out_valid_i input NumGroups: per-group result valid.
REQ-013 SHALL have grp_out_ready_o output NumGroups: per-group result ready.
REQ-014 SHALL have grp_result_i input NumGroups x Width and grp_status_i input NumGroups x 5: per-group result and NV/DZ/OF/UF/NX flags.
REQ-015 SHALL have out_valid_o output 1, out_ready_i input 1, result_o output Width, status_o output 5, tag_o output TagWidth: retired result.
REQ-016 SHALL have flush_i input 1: discard all in-flight operations.
REQ-017 SHALL have busy_o output 1, outstanding_o output $clog2(Depth+1), err_o output 1 (sticky illegal-group flag).

Function
REQ-018 SHALL keep an order FIFO of Depth entries {group, tag}, with read/write pointers wrapping modulo Depth and a count 0..Depth.
REQ-019 SHALL define legal = (in_group_i < NumGroups), and go = in_valid_i & legal & grp_in_ready_i[in_group_i] & (count != Depth) & !flush_i.
REQ-020 SHALL drive in_ready_o = go, and grp_in_valid_o[g] = in_valid_i & legal & (in_group_i == g) & (count != Depth) & !flush_i, with all other bits 0.
REQ-021 SHALL push {in_group_i, in_tag_i} on go; a full FIFO SHALL block dispatch even if a retire occurs in the same cycle (no out_ready_i-to-in_ready_o combinational path).
REQ-022 SHALL, with head group h, drive out_valid_o = (count != 0) & grp_out_valid_i[h] & !flush_i, and result_o/status_o from group h with tag_o from the FIFO head (zero-latency pass-through).
REQ-023 SHALL drive grp_out_ready_o[h] = out_ready_i & (count != 0) & !flush_i; non-head groups SHALL see 0 and stall, which guarantees program-order retirement.
REQ-024 SHALL pop the FIFO on out_valid_o & out_ready_i.
REQ-025 SHALL update the count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-026 SHALL drive result_o, status_o and tag_o to 0 when count == 0.
REQ-027 SHALL, while flush_i is 1, drive grp_out_ready_o all-ones (drain), out_valid_o = 0 and in_ready_o = 0, and at the clock edge reset the pointers and count to 0.
REQ-028 SHALL, on in_valid_i & !legal, set err_o (sticky until reset), never assert in_ready_o, and not push.
REQ-029 SHALL drive busy_o = (count != 0) and outstanding_o = count.

Reset
REQ-030 SHALL, when rst_i is 1 at a rising edge, clear the pointers, count and err_o; from the next cycle in_ready_o follows REQ-019, and out_valid_o, busy_o, outstanding_o and err_o are 0.
REQ-031 SHALL, on a reset mid-operation, discard all FIFO entries with no retire, and ignore any stale group results (a group output is only consumed at the FIFO head).

Verification
REQ-032 SHALL cover in order: dispatch tag 0x11 to group 0 (latency 4) then tag 0x22 to group 3 (latency 1); group 3 result becomes valid first -> it is stalled; out emits tag 0x11 then 0x22, and outstanding_o goes 0,1,2,...,0.
REQ-033 SHALL cover full: with Depth=8 and out_ready_i=0, 8 dispatches are accepted; the 9th sees in_ready_o=0 even with out_ready_i=1 pulsed that cycle; the next cycle it is accepted.
REQ-034 SHALL cover wrap: 20 back-to-back dispatch/retire pairs with Depth=8 -> tags 0..19 are retired in order with no loss; outstanding_o never exceeds 8.
REQ-035 SHALL cover flush: flush_i pulsed with 3 entries outstanding -> out_valid_o=0 that cycle and grp_out_ready_o=all-ones; the next cycle busy_o=0 and outstanding_o=0.
REQ-036 SHALL cover illegal group: in_group_i=6 with NumGroups=5 -> in_ready_o=0, no grp_in_valid_o, err_o=1 the next cycle and held until rst_i.
REQ-037 SHALL cover a reset mid-stream: rst_i asserted with 5 outstanding -> outstanding_o=0 the next cycle, and a result asserted afterwards by a group does not produce out_valid_o.
